// File: rtl/spi_flash_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder_if
// Description : SPI bus and memory fetch port bundle for the flash responder.
//               The slave side is the responder; the master side is the SPI
//               loader plus the backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_flash_responder_if #(
    parameter int ADDR_WRAP_BITS = 24
);
    logic                      nCS;
    logic                      CLK;
    logic                      MOSI;
    logic                      MISO;
    logic                      MISO_OE;
    logic [ADDR_WRAP_BITS-1:0] MEMADDR;
    logic                      MEMRD;
    logic [7:0]                MEMDATA;
    logic                      CMDERR;
    logic [7:0]                LASTCMD;

    modport slave (
        input  nCS, CLK, MOSI, MEMDATA,
        output MISO, MISO_OE, MEMADDR, MEMRD, CMDERR, LASTCMD
    );

    modport master (
        output nCS, CLK, MOSI, MEMDATA,
        input  MISO, MISO_OE, MEMADDR, MEMRD, CMDERR, LASTCMD
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : W25Q32-style SPI flash stand-in. Oversamples the SPI pins on
//               MCLK, decodes READ (03), FAST READ (0B) and JEDEC ID (9F),
//               fetches bytes from a synchronous memory port and shifts them
//               out on MISO (mode 0).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int          MEM_LATENCY    = 1,
    parameter logic [23:0] JEDEC_ID       = 24'hEF4016,
    parameter int          ADDR_WRAP_BITS = 24
) (
    input  logic                 MCLK,
    input  logic                 RST,
    spi_flash_responder_if.slave bus
);

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FAST  = 8'h0B;
    localparam logic [7:0] OP_JEDEC = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_ID     = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    // Synchroniser chains; clk_sync carries one extra flop for edge detection
    logic [1:0] cs_sync;
    logic       cs_prev;
    logic [2:0] clk_sync;
    logic [1:0] mosi_sync;

    logic       cs_high;
    logic       cs_fall;
    logic       clk_rise;
    logic       clk_fall;
    logic       mosi_bit;

    logic [22:0]               shift_in;
    logic [4:0]                rx_cnt;
    logic [2:0]                tx_cnt;
    logic [7:0]                tx_shift;
    logic [7:0]                next_byte;
    logic [1:0]                id_idx;
    logic [7:0]                id_next;
    logic [7:0]                cmd_byte;
    logic [23:0]               addr_word;
    logic [MEM_LATENCY-1:0]    rd_pipe;
    logic                      rd_hit;

    logic                      tx_line;
    logic                      tx_en;
    logic [ADDR_WRAP_BITS-1:0] mem_addr;
    logic                      mem_rd;
    logic                      cmd_err;
    logic [7:0]                last_cmd;

    assign bus.MISO    = tx_line;
    assign bus.MISO_OE = tx_en;
    assign bus.MEMADDR = mem_addr;
    assign bus.MEMRD   = mem_rd;
    assign bus.CMDERR  = cmd_err;
    assign bus.LASTCMD = last_cmd;

    // Idle levels are preloaded so reset release never looks like a select
    always_ff @(posedge MCLK) begin
        if (RST) begin
            cs_sync   <= 2'b11;
            cs_prev   <= 1'b1;
            clk_sync  <= 3'b000;
            mosi_sync <= 2'b00;
        end else begin
            cs_sync   <= {cs_sync[0], bus.nCS};
            cs_prev   <= cs_sync[1];
            clk_sync  <= {clk_sync[1:0], bus.CLK};
            mosi_sync <= {mosi_sync[0], bus.MOSI};
        end
    end

    // A deasserted select masks CLK edges, so a simultaneous nCS rise wins
    assign cs_high   = cs_sync[1];
    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign clk_rise  = clk_sync[1] & ~clk_sync[2] & ~cs_high;
    assign clk_fall  = ~clk_sync[1] & clk_sync[2] & ~cs_high;
    assign mosi_bit  = mosi_sync[1];
    assign cmd_byte  = {shift_in[6:0], mosi_bit};
    assign addr_word = {shift_in, mosi_bit};

    // Read strobe delay line marking when MEMDATA is valid
    generate
        if (MEM_LATENCY == 1) begin : g_lat_one
            always_ff @(posedge MCLK) begin
                if (RST) rd_pipe <= '0;
                else     rd_pipe <= mem_rd;
            end
        end else begin : g_lat_multi
            always_ff @(posedge MCLK) begin
                if (RST) rd_pipe <= '0;
                else     rd_pipe <= {rd_pipe[MEM_LATENCY-2:0], mem_rd};
            end
        end
    endgenerate
    assign rd_hit = rd_pipe[MEM_LATENCY-1];

    // JEDEC ID byte selected by the rotating index
    always_comb begin
        id_next = JEDEC_ID[7:0];
        case (id_idx)
            2'd0:    id_next = JEDEC_ID[23:16];
            2'd1:    id_next = JEDEC_ID[15:8];
            default: id_next = JEDEC_ID[7:0];
        endcase
    end

    // State register
    always_ff @(posedge MCLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; a high select returns to IDLE from anywhere
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cs_fall) state_next = ST_CMD;
            end
            ST_CMD: begin
                if (clk_rise && rx_cnt == 5'd7) begin
                    if (cmd_byte == OP_READ || cmd_byte == OP_FAST)
                        state_next = ST_ADDR;
                    else if (cmd_byte == OP_JEDEC)
                        state_next = ST_ID;
                    else
                        state_next = ST_IGNORE;
                end
            end
            ST_ADDR: begin
                if (clk_rise && rx_cnt == 5'd23)
                    state_next = (last_cmd == OP_FAST) ? ST_DUMMY : ST_DATA;
            end
            ST_DUMMY: begin
                if (clk_rise && rx_cnt == 5'd7) state_next = ST_DATA;
            end
            default: state_next = state;
        endcase
        if (cs_high) state_next = ST_IDLE;
    end

    // Shift, count, memory fetch and MISO serialisation datapath
    always_ff @(posedge MCLK) begin
        if (RST) begin
            shift_in  <= '0;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            tx_shift  <= '0;
            next_byte <= '0;
            id_idx    <= '0;
            tx_line   <= 1'b1;
            tx_en     <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            cmd_err   <= 1'b0;
            last_cmd  <= '0;
        end else begin
            mem_rd  <= 1'b0;
            cmd_err <= 1'b0;

            // Prefetch results arriving after an abort are dropped
            if ((state == ST_DATA || state == ST_DUMMY) && rd_hit)
                next_byte <= bus.MEMDATA;

            if (state != state_next)
                rx_cnt <= '0;
            else if (clk_rise)
                rx_cnt <= rx_cnt + 5'd1;

            if (clk_rise && (state == ST_CMD || state == ST_ADDR))
                shift_in <= {shift_in[21:0], mosi_bit};

            case (state)
                ST_IDLE: begin
                    tx_line <= 1'b1;
                    tx_en   <= 1'b0;
                    tx_cnt  <= '0;
                end
                ST_CMD: begin
                    if (clk_rise && rx_cnt == 5'd7) begin
                        last_cmd <= cmd_byte;
                        if (cmd_byte == OP_JEDEC) begin
                            tx_shift <= JEDEC_ID[23:16];
                            id_idx   <= 2'd1;
                        end else if (cmd_byte != OP_READ && cmd_byte != OP_FAST) begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (clk_rise && rx_cnt == 5'd23) begin
                        mem_addr <= addr_word[ADDR_WRAP_BITS-1:0];
                        mem_rd   <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_fall) begin
                        tx_en  <= 1'b1;
                        tx_cnt <= tx_cnt + 3'd1;
                        if (tx_cnt == 3'd0) begin
                            // New byte: take the prefetched value, fetch the next
                            tx_line  <= next_byte[7];
                            tx_shift <= {next_byte[6:0], 1'b0};
                            mem_addr <= mem_addr + {{(ADDR_WRAP_BITS-1){1'b0}}, 1'b1};
                            mem_rd   <= 1'b1;
                        end else begin
                            tx_line  <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_ID: begin
                    if (clk_fall) begin
                        tx_en   <= 1'b1;
                        tx_line <= tx_shift[7];
                        tx_cnt  <= tx_cnt + 3'd1;
                        if (tx_cnt == 3'd7) begin
                            tx_shift <= id_next;
                            id_idx   <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    tx_line <= 1'b1;
                    tx_en   <= 1'b0;
                end
            endcase

            if (cs_high) begin
                tx_line <= 1'b1;
                tx_en   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
